// File: rtl/cmd_width_downsizer.sv
// Splits each IN_WIDTH-bit command into RATIO OUT_WIDTH-bit beats on a valid/ready master port.
// Optional macro CMD_DOWNSIZER_MSB_FIRST_EN: emit the most-significant slice first.
module cmd_width_downsizer #(
  parameter  int unsigned IN_WIDTH  = 32,
  parameter  int unsigned OUT_WIDTH = 8,
  localparam int unsigned RATIO     = IN_WIDTH / OUT_WIDTH,
  localparam int unsigned CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_WIDTH-1:0]  s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic [CNT_W-1:0]     m_beat_idx
);

  if ((OUT_WIDTH == 0) || ((IN_WIDTH % OUT_WIDTH) != 0)) begin : g_bad_ratio
    $error("cmd_width_downsizer: IN_WIDTH must be an integer multiple of OUT_WIDTH");
  end

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

  state_t              state_q, state_d;
  logic [IN_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [IN_WIDTH-1:0] shreg_next;

`ifdef CMD_DOWNSIZER_MSB_FIRST_EN
  assign m_data     = shreg_q[IN_WIDTH-1 -: OUT_WIDTH];
  assign shreg_next = shreg_q << OUT_WIDTH;
`else
  assign m_data     = shreg_q[OUT_WIDTH-1:0];
  assign shreg_next = shreg_q >> OUT_WIDTH;
`endif

  assign m_valid    = (state_q == SEND);
  assign m_last     = (state_q == SEND) && (idx_q == LAST_IDX);
  assign m_beat_idx = idx_q;
  // Only combinational path: m_ready -> s_ready, enabling the zero-bubble reload.
  assign s_ready    = (state_q == IDLE) || ((state_q == SEND) && m_ready && m_last);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          shreg_d = s_data;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (m_ready) begin
          if (!m_last) begin
            shreg_d = shreg_next;
            idx_d   = idx_q + CNT_W'(1);
          end else if (s_valid) begin
            shreg_d = s_data;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_cmd_width_downsizer.sv
// Scoreboard bench for cmd_width_downsizer (IN=32, OUT=8): directed scenarios plus random stress.
module tb_cmd_width_downsizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic [1:0]  m_beat_idx;

  cmd_width_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .m_beat_idx(m_beat_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic [1:0] idx;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    beats = 0;

  function automatic logic [7:0] slice(input logic [31:0] c, input int i);
`ifdef CMD_DOWNSIZER_MSB_FIRST_EN
    return c[(3-i)*8 +: 8];
`else
    return c[i*8 +: 8];
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Producer: an accepted command queues its four expected beats; reset abandons them.
  always @(negedge clk) begin : producer
    beat_t b;
    if (reset) begin
      exp_q.delete();
    end else if (s_valid && s_ready) begin
      for (int i = 0; i < 4; i++) begin
        b.d    = slice(s_data, i);
        b.last = (i == 3);
        b.idx  = 2'(i);
        exp_q.push_back(b);
      end
    end
  end

  // Monitor: every beat handshake must match the head of the expected queue.
  always @(negedge clk) begin : monitor
    beat_t b;
    if (!reset && m_valid && m_ready) begin
      beats++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got %0h want none at %0t", m_data, $time);
      end else begin
        b = exp_q.pop_front();
        chk("beat_data", 32'(m_data), 32'(b.d));
        chk("beat_last", 32'(m_last), 32'(b.last));
        chk("beat_idx", 32'(m_beat_idx), 32'(b.idx));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string name, input logic [31:0] cmd, input int i);
    chk({name, "_valid"}, 32'(m_valid), 32'd1);
    chk({name, "_data"}, 32'(m_data), 32'(slice(cmd, i)));
    chk({name, "_idx"}, 32'(m_beat_idx), 32'(i));
    chk({name, "_last"}, 32'(m_last), 32'(i == 3));
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] c0, c1;
    int          beats0, sent, guard;
    logic        hs;

    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    tick; tick;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_idx", 32'(m_beat_idx), 32'd0);
    reset = 1'b0;
    m_ready = 1'b1;

    // Single command
    c0 = 32'hA1B2C3D4;
    tick;
    s_valid = 1'b1; s_data = c0;
    #1 chk("t1_s_ready_idle", 32'(s_ready), 32'd1);
    tick;
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_beat("t1", c0, i);
      tick;
    end
    chk("t1_idle_after", 32'(m_valid), 32'd0);

    // Back-to-back, zero bubble
    c0 = 32'h11223344; c1 = 32'h55667788;
    s_valid = 1'b1; s_data = c0;
    tick;
    s_data = c1;
    for (int j = 0; j < 8; j++) begin
      check_beat("t2", (j < 4) ? c0 : c1, j % 4);
      if (j < 3) chk("t2_s_ready_busy", 32'(s_ready), 32'd0);
      if (j == 3) chk("t2_s_ready_last", 32'(s_ready), 32'd1);
      tick;
      if (j == 3) s_valid = 1'b0;
    end
    chk("t2_idle_after", 32'(m_valid), 32'd0);

    // Backpressure on beat 1
    c0 = 32'hA1B2C3D4;
    s_valid = 1'b1; s_data = c0;
    tick;
    s_valid = 1'b0;
    check_beat("t3_b0", c0, 0);
    tick;
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'hCAFEF00D;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_beat("t3_hold", c0, 1);
      chk("t3_s_ready", 32'(s_ready), 32'd0);
      tick;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    #1 check_beat("t3_release", c0, 1);
    tick;
    check_beat("t3_resume", c0, 2);
    tick; tick;
    chk("t3_idle_after", 32'(m_valid), 32'd0);

    // Reset mid-command: after beat 1 accepted, reset while beat 2 is presented
    s_valid = 1'b1; s_data = c0;
    tick;
    s_valid = 1'b0;
    tick;
    check_beat("t4_b1", c0, 1);
    tick;
    reset = 1'b1;
    s_valid = 1'b1; s_data = 32'h12345678;
    tick;
    reset = 1'b0;
    s_valid = 1'b0;
    chk("t4_rst_valid", 32'(m_valid), 32'd0);
    chk("t4_rst_data", 32'(m_data), 32'd0);
    chk("t4_rst_last", 32'(m_last), 32'd0);
    chk("t4_rst_idx", 32'(m_beat_idx), 32'd0);
    tick;
    chk("t4_no_stale", 32'(m_valid), 32'd0);
    c1 = 32'hDEADBEEF;
    s_valid = 1'b1; s_data = c1;
    tick;
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_beat("t4_new", c1, i);
      tick;
    end

    // Random stress
    beats0 = beats;
    sent = 0;
    guard = 0;
    while (sent < 1000 && guard < 20000) begin
      if (!s_valid && ($urandom % 3) != 0) begin
        s_valid = 1'b1;
        s_data  = $urandom;
      end
      m_ready = ($urandom % 4) != 0;
      #1;
      hs = s_valid && s_ready;
      tick;
      guard++;
      if (hs) begin
        sent++;
        s_valid = 1'b0;
      end
    end
    chk("stress_sent", 32'(sent), 32'd1000);
    m_ready = 1'b1;
    guard = 0;
    while ((m_valid || exp_q.size() != 0) && guard < 50) begin
      tick;
      guard++;
    end
    chk("stress_drained", 32'(guard < 50), 32'd1);
    chk("stress_beats", 32'(beats - beats0), 32'd4000);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
